// File: rtl/rx_phy_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : rx_phy_pkg                                                    |
// | Brief   : Shared receive-PHY constants and lane alignment state codes.  |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package rx_phy_pkg;

  // Comma symbol used by every receive block for byte alignment.
  localparam logic [7:0] COM_SYM = 8'hBC;

  // Alignment controller states; the encoding is visible on state_out.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_LOCKED = 2'b10
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/rx_com_window.sv
// ---------------------------------------------------------------------------
// | Module  : rx_com_window                                                 |
// | Brief   : 8-bit sliding window over the serial lane plus COM detector.  |
// |           The newest bit is taken straight from data_in so a symbol     |
// |           is recognised in the same cycle its last bit arrives.         |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module rx_com_window #(
  parameter logic [7:0] COM_SYM = rx_phy_pkg::COM_SYM
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] w,
  output logic       is_com
);
  import rx_phy_pkg::*;

  logic [6:0] r_sr;

  // Seven most recent bits, MSB first, shifted on every clock.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_sr <= 7'd0;
    end else begin
      r_sr <= {r_sr[5:0], data_in};
    end
  end

  assign w      = {r_sr, data_in};
  assign is_com = (w == COM_SYM);

endmodule

`default_nettype wire

// File: rtl/rx_align_ctrl.sv
// ---------------------------------------------------------------------------
// | Module  : rx_align_ctrl                                                 |
// | Brief   : Byte alignment and lock controller for one receive lane.      |
// |           Hunts for COM at any bit offset, qualifies lock on LOCK_CNT   |
// |           consecutive COMs, then emits aligned bytes. Lock is dropped   |
// |           on COM starvation (MAX_GAP boundaries) or on resync.          |
// |           Optional macro RX_ALIGN_STATS_EN adds lock_loss_cnt and       |
// |           com_err status outputs.                                       |
// | Rev     : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module rx_align_ctrl #(
  parameter logic [7:0]  COM_SYM  = rx_phy_pkg::COM_SYM,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MAX_GAP  = 255
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       resync,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       locked,
  output logic [1:0] state_out
`ifdef RX_ALIGN_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic       com_err
`endif
);
  import rx_phy_pkg::*;

  localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);
  localparam logic [7:0] c_max_gap  = 8'(MAX_GAP);

  rx_state_e  r_state;
  rx_state_e  w_state_nxt;
  logic [2:0] r_ph;
  logic [3:0] r_comcnt;
  logic [7:0] r_gap;
  logic [7:0] w_win;
  logic       w_is_com;
  logic       w_boundary;
  logic       w_emit;
  logic [3:0] w_comcnt_inc;
  logic [7:0] w_gap_inc;

  rx_com_window #(
    .COM_SYM (COM_SYM)
  ) u_window (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .w       (w_win),
    .is_com  (w_is_com)
  );

  assign w_boundary   = (r_ph == 3'd7);
  assign w_comcnt_inc = r_comcnt + 4'd1;
  assign w_gap_inc    = r_gap + 8'd1;
  // resync wins over a coincident boundary, so no byte leaves on that edge.
  assign w_emit       = (r_state == ST_LOCKED) && w_boundary && !resync;
  assign state_out    = r_state;

  // Next-state decision; resync forces a re-hunt from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (resync) begin
      w_state_nxt = ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_is_com) w_state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          if (w_boundary) begin
            if (!w_is_com)                       w_state_nxt = ST_HUNT;
            else if (w_comcnt_inc == c_lock_cnt) w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_boundary && !w_is_com && (w_gap_inc == c_max_gap))
            w_state_nxt = ST_HUNT;
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // State register; locked tracks the same next-state so both move together.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_state <= ST_HUNT;
      locked  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      locked  <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Phase, COM qualification and COM-gap counters.
  always_ff @(posedge clk_32f) begin
    if (!reset || resync) begin
      r_ph     <= 3'd0;
      r_comcnt <= 4'd0;
      r_gap    <= 8'd0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_is_com) begin
            r_ph     <= 3'd0;
            r_comcnt <= 4'd1;
          end
        end
        ST_CHECK: begin
          r_ph <= r_ph + 3'd1;
          if (w_boundary) begin
            if (w_is_com) begin
              r_comcnt <= w_comcnt_inc;
              if (w_comcnt_inc == c_lock_cnt) r_gap <= 8'd0;
            end else begin
              r_comcnt <= 4'd0;
            end
          end
        end
        ST_LOCKED: begin
          r_ph <= r_ph + 3'd1;
          if (w_boundary) r_gap <= w_is_com ? 8'd0 : w_gap_inc;
        end
        default: begin
          r_ph <= 3'd0;
        end
      endcase
    end
  end

  // Aligned byte output; data_out and valid_out hold between strobes.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      data_out  <= 8'd0;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
    end else begin
      byte_stb <= w_emit;
      if (resync) begin
        valid_out <= 1'b0;
      end else if (w_emit) begin
        data_out  <= w_win;
        valid_out <= !w_is_com;
      end
    end
  end

`ifdef RX_ALIGN_STATS_EN
  // Saturating count of lock losses and a pulse on each failed qualification.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      lock_loss_cnt <= 8'd0;
      com_err       <= 1'b0;
    end else begin
      if ((r_state == ST_LOCKED) && (w_state_nxt == ST_HUNT) && (lock_loss_cnt != 8'hFF))
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      com_err <= (r_state == ST_CHECK) && !resync && w_boundary && !w_is_com;
    end
  end
`endif

endmodule

`default_nettype wire
